// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_tx_scheduler_pkg;

  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned GRANT_W           = 3;
  localparam int unsigned START_TIMEOUT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// Combinational round-robin picker: first valid index after last_i, wrapping.
module uart_tx_scheduler_rr_pick
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]   valid_i,
  input  logic [GRANT_W-1:0] last_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               any_valid_o
);

  always_comb begin
    int unsigned idx;
    logic        found;
    idx      = 0;
    found    = 1'b0;
    winner_o = '0;
    // Offsets 1..N_REQ visit last+1 first and last itself at the very end.
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_i) + k) % N_REQ;
      if (!found && valid_i[idx]) begin
        found    = 1'b1;
        winner_o = GRANT_W'(idx);
      end
    end
    any_valid_o = |valid_i;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Arbitrates N_REQ byte sources onto one UART transmitter, one frame at a time,
// with a start-handshake timeout and a one-cycle idle gap between frames.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    tx_en,
  output logic                    tx_begin,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic [GRANT_W-1:0]      grant_id,
  output logic                    active,
  output logic                    timeout_err
);

  localparam int unsigned CNT_W = $clog2(START_TIMEOUT + 1);

  sched_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic [GRANT_W-1:0]  last_q, last_d;
  logic                err_q, err_d;
  logic                tx_begin_q;
  logic                active_q;
  logic                tx_en_q;

  logic [GRANT_W-1:0]  winner;
  logic                any_valid;

  uart_tx_scheduler_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .valid_i     (req_valid),
    .last_i      (last_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // Next-state logic; req_ready is the handshake strobe, valid in the cycle the grant is taken.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    grant_d   = grant_q;
    last_d    = last_q;
    err_d     = err_q;
    req_ready = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A busy transmitter here is a foreign or stale frame; wait it out.
        if (enable && any_valid && !tx_busy) begin
          state_d   = ST_START;
          cnt_d     = '0;
          data_d    = BYTE_W'(req_data >> (BYTE_W * winner));
          grant_d   = winner;
          last_d    = winner;
          req_ready = N_REQ'(1) << winner;
        end
      end
      ST_START: begin
        if (tx_busy) begin
          state_d = ST_SEND;
        end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SEND: begin
        if (!tx_busy) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      grant_q    <= '0;
      last_q     <= GRANT_W'(N_REQ - 1);
      err_q      <= 1'b0;
      tx_begin_q <= 1'b0;
      active_q   <= 1'b0;
      tx_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      err_q      <= err_d;
      tx_begin_q <= (state_d == ST_START);
      active_q   <= (state_d != ST_IDLE);
      tx_en_q    <= 1'b1;
    end
  end

  assign tx_en       = tx_en_q;
  assign tx_begin    = tx_begin_q;
  assign tx_data     = data_q;
  assign grant_id    = grant_q;
  assign active      = active_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a behavioural UART transmitter stub.
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic        tx_begin;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [2:0]  grant_id;
  logic        active;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_en       (tx_en),
    .tx_begin    (tx_begin),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .active      (active),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter stub: start bit, 8 data bits LSB first, stop bit, one cycle each.
  logic       stub_on;
  logic       busy_force;
  logic       stub_busy;
  logic [3:0] bitcnt;
  logic [7:0] rx_sh;
  logic       line;
  logic [7:0] rx_log [64];
  int         rx_n = 0;

  assign tx_busy = (stub_on & stub_busy) | busy_force;

  always_comb begin
    line = 1'b1;
    if (stub_busy) begin
      if (bitcnt == 4'd0)      line = 1'b0;
      else if (bitcnt <= 4'd8) line = tx_data[bitcnt - 4'd1];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0;
      bitcnt    <= '0;
    end else if (!stub_busy) begin
      if (stub_on && tx_begin) begin
        stub_busy <= 1'b1;
        bitcnt    <= '0;
      end
    end else begin
      if (bitcnt >= 4'd1 && bitcnt <= 4'd8) rx_sh[bitcnt - 4'd1] <= line;
      if (bitcnt == 4'd9) begin
        stub_busy     <= 1'b0;
        rx_log[rx_n]  <= rx_sh;
        rx_n          <= rx_n + 1;
      end
      bitcnt <= bitcnt + 4'd1;
    end
  end

  // Grant monitor: logs every req_ready strobe taken on a rising edge.
  logic [3:0] gvec [64];
  int         gn = 0;

  always @(posedge clk) begin
    if (rst_n && req_ready != 4'd0) begin
      gvec[gn] <= req_ready;
      gn       <= gn + 1;
    end
  end

  task automatic wait_grants(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (gn >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (rx_n >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    enable     = 1'b1;
    req_valid  = 4'd0;
    req_data   = 32'd0;
    stub_on    = 1'b1;
    busy_force = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [18:0] outs;
    rst_n = 1'b1;
    do_reset();
    rst_n = 1'b0;
    #1;
    outs = {tx_en, tx_begin, tx_data, grant_id, req_ready, active, timeout_err};
    checks++;
    if (outs !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want %h", outs, 19'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_en !== 1'b1) begin
      errors++;
      $display("FAIL tx_en_after_reset got %b want 1", tx_en);
    end
  endtask

  task automatic test_single();
    bit ok;
    int g0, r0;
    do_reset();
    g0 = gn; r0 = rx_n;
    req_data  = 32'h0000_0055;
    req_valid = 4'b0001;
    wait_grants(g0 + 1, 20, ok);
    checks++;
    if (!ok || gvec[g0] !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got ok=%0b vec=%b want 0001", ok, gvec[g0]);
    end
    checks++;
    if ({tx_begin, active, tx_data, grant_id} !== {1'b1, 1'b1, 8'h55, 3'd0}) begin
      errors++;
      $display("FAIL single_start got begin=%b act=%b data=%h id=%0d want 1 1 55 0",
               tx_begin, active, tx_data, grant_id);
    end
    req_valid = 4'b0000;
    wait_rx(r0 + 1, 40, ok);
    checks++;
    if (!ok || rx_log[r0] !== 8'h55) begin
      errors++;
      $display("FAIL single_serial got ok=%0b byte=%h want 55", ok, rx_log[r0]);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (gn - g0 !== 1) begin
      errors++;
      $display("FAIL single_count got %0d want 1", gn - g0);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int g0, r0;
    logic [3:0] exp_vec [5];
    logic [7:0] exp_byte [5];
    exp_vec  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_byte = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h10};
    do_reset();
    g0 = gn; r0 = rx_n;
    req_data  = {8'h40, 8'h30, 8'h20, 8'h10};
    req_valid = 4'b1111;
    wait_grants(g0 + 5, 200, ok);
    req_valid = 4'b0000;
    wait_rx(r0 + 5, 60, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (gvec[g0 + i] !== exp_vec[i]) begin
        errors++;
        $display("FAIL rr_grant%0d got %b want %b", i, gvec[g0 + i], exp_vec[i]);
      end
      checks++;
      if (rx_log[r0 + i] !== exp_byte[i]) begin
        errors++;
        $display("FAIL rr_byte%0d got %h want %h", i, rx_log[r0 + i], exp_byte[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int g0;
    do_reset();
    g0 = gn;
    req_data  = {8'hD3, 8'h00, 8'h00, 8'hA0};
    req_valid = 4'b1000;
    wait_grants(g0 + 2, 60, ok);
    req_valid = 4'b1001;
    wait_grants(g0 + 3, 60, ok);
    req_valid = 4'b0000;
    checks++;
    if (gvec[g0] !== 4'b1000 || gvec[g0 + 1] !== 4'b1000) begin
      errors++;
      $display("FAIL wrap_repeat got %b,%b want 1000,1000", gvec[g0], gvec[g0 + 1]);
    end
    checks++;
    if (!ok || gvec[g0 + 2] !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_to_zero got ok=%0b vec=%b want 0001", ok, gvec[g0 + 2]);
    end
    wait_rx(rx_n + 1, 40, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int g0, r0;
    do_reset();
    stub_on   = 1'b0;
    g0 = gn;
    req_data  = {8'h00, 8'h00, 8'hBB, 8'hAA};
    req_valid = 4'b0001;
    wait_grants(g0 + 1, 20, ok);
    req_valid = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({active, tx_begin, timeout_err} !== 3'b110) begin
        errors++;
        $display("FAIL timeout_wait%0d got %b want 110", i, {active, tx_begin, timeout_err});
      end
      @(negedge clk);
    end
    checks++;
    if ({active, tx_begin, timeout_err} !== 3'b001) begin
      errors++;
      $display("FAIL timeout_fire got %b want 001", {active, tx_begin, timeout_err});
    end
    stub_on = 1'b1;
    r0 = rx_n;
    req_valid = 4'b0010;
    wait_grants(g0 + 2, 20, ok);
    req_valid = 4'b0000;
    wait_rx(r0 + 1, 40, ok);
    checks++;
    if (!ok || gvec[g0 + 1] !== 4'b0010 || rx_log[r0] !== 8'hBB || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_recover got ok=%0b vec=%b byte=%h err=%b want 0010 bb 1",
               ok, gvec[g0 + 1], rx_log[r0], timeout_err);
    end
  endtask

  task automatic test_enable();
    bit ok;
    int g0, r0;
    do_reset();
    g0 = gn; r0 = rx_n;
    req_data  = {8'h00, 8'h00, 8'h62, 8'h61};
    req_valid = 4'b0011;
    wait_grants(g0 + 1, 20, ok);
    wait_busy(20, ok);
    @(negedge clk);
    enable = 1'b0;
    wait_rx(r0 + 1, 40, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (gn - g0 !== 1 || active !== 1'b0 || rx_log[r0] !== 8'h61) begin
      errors++;
      $display("FAIL enable_hold got grants=%0d act=%b byte=%h want 1 0 61",
               gn - g0, active, rx_log[r0]);
    end
    enable = 1'b1;
    wait_grants(g0 + 2, 20, ok);
    req_valid = 4'b0000;
    checks++;
    if (!ok || gvec[g0 + 1] !== 4'b0010) begin
      errors++;
      $display("FAIL enable_resume got ok=%0b vec=%b want 0010", ok, gvec[g0 + 1]);
    end
    wait_rx(r0 + 2, 40, ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int g0, r0;
    logic [18:0] outs;
    do_reset();
    g0 = gn;
    req_data  = {8'h00, 8'h00, 8'h78, 8'h77};
    req_valid = 4'b0001;
    wait_grants(g0 + 1, 20, ok);
    req_valid = 4'b0000;
    wait_busy(20, ok);
    repeat (3) @(negedge clk);
    r0 = rx_n;
    rst_n = 1'b0;
    #1;
    outs = {tx_en, tx_begin, tx_data, grant_id, req_ready, active, timeout_err};
    checks++;
    if (outs !== 19'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %h want %h", outs, 19'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (gn - g0 !== 1 || rx_n !== r0) begin
      errors++;
      $display("FAIL midreset_no_reissue got grants=%0d frames=%0d want 1 0", gn - g0, rx_n - r0);
    end
    req_valid = 4'b0011;
    wait_grants(g0 + 2, 20, ok);
    req_valid = 4'b0000;
    checks++;
    if (!ok || gvec[g0 + 1] !== 4'b0001) begin
      errors++;
      $display("FAIL midreset_last_grant got ok=%0b vec=%b want 0001", ok, gvec[g0 + 1]);
    end
    wait_rx(r0 + 1, 40, ok);
  endtask

  task automatic test_busy_block();
    bit ok;
    int g0;
    do_reset();
    g0 = gn;
    busy_force = 1'b1;
    req_data   = 32'h0000_0099;
    req_valid  = 4'b0001;
    repeat (10) @(negedge clk);
    checks++;
    if (gn !== g0 || active !== 1'b0) begin
      errors++;
      $display("FAIL busy_block got grants=%0d act=%b want 0 0", gn - g0, active);
    end
    busy_force = 1'b0;
    wait_grants(g0 + 1, 20, ok);
    req_valid = 4'b0000;
    checks++;
    if (!ok || gvec[g0] !== 4'b0001) begin
      errors++;
      $display("FAIL busy_release got ok=%0b vec=%b want 0001", ok, gvec[g0]);
    end
    wait_rx(rx_n + 1, 40, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_timeout();
    test_enable();
    test_reset_mid();
    test_busy_block();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
